id_ctrl_stage: RTL and testbench

ID_CTRL_STAGE -- requirements
Module: id_ctrl_stage

---
 rtl/id_ctrl_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_id_ctrl_stage.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ctrl_stage.sv
// Instruction-decode control stage: decodes the ID instruction, resolves hazards and registers the EX control bundle.
// Optional multiply/divide unit decode and busy tracking is enabled by defining ID_CTRL_MDU_EN.
module id_ctrl_stage #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 12,
    parameter int RA_REG   = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_id,
    input  logic        id_valid,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        stall_id,
    output logic        ex_valid,
    output logic        ex_regwrite,
    output logic        ex_memwrite,
    output logic        ex_memread,
    output logic        ex_memtoreg,
    output logic        ex_alusrc,
    output logic        ex_is_shift,
    output logic        ex_branch,
    output logic        ex_branch_ne,
    output logic        ex_jump,
    output logic        ex_jr,
    output logic        ex_wb_pc_plus4,
    output logic [3:0]  ex_alu_ctrl,
    output logic [4:0]  ex_wdst,
    output logic [2:0]  ex_mdu_op,
    output logic        ex_illegal,
    output logic        mdu_busy
);

    localparam logic [3:0] MULT_LAT_W = 4'(MULT_LAT);
    localparam logic [3:0] DIV_LAT_W  = 4'(DIV_LAT);
    localparam logic [4:0] RA_W       = 5'(RA_REG);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW  = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR  = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26, F_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011, ALU_SUB = 4'b0110, ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000, ALU_LUI = 4'b1001, ALU_SRL = 4'b1010;
    localparam logic [3:0] ALU_SRA = 4'b1011;

`ifdef ID_CTRL_MDU_EN
    localparam logic [5:0] F_MFHI = 6'h10, F_MFLO = 6'h12, F_MULT = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
    localparam logic [2:0] MDU_NONE = 3'd0, MDU_MULT = 3'd1, MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV = 3'd3, MDU_DIVU = 3'd4, MDU_MFHI = 3'd5, MDU_MFLO = 3'd6;
`endif

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic       memread;
        logic       memtoreg;
        logic       alusrc;
        logic       is_shift;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       jr;
        logic       wb_pc_plus4;
        logic [3:0] alu_ctrl;
        logic [4:0] wdst;
        logic [2:0] mdu_op;
        logic       illegal;
    } ctrl_t;

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd;
    ctrl_t      dec_p0;
    ctrl_t      ex_q_p1;
    logic       vld_p1;
    logic       uses_rt_p0, load_use_p0, mdu_hz_p0, hold_p0, bubble_p0, issue_p0;

    assign opcode = instr_id[31:26];
    assign rs     = instr_id[25:21];
    assign rt     = instr_id[20:16];
    assign rd     = instr_id[15:11];
    assign funct  = instr_id[5:0];

    // ---- ID: combinational decode ----
    always_comb begin
        dec_p0 = '0;
        if (instr_id != 32'd0) begin
            case (opcode)
                OP_RTYPE: begin
                    dec_p0.wdst = rd;
                    case (funct)
                        F_ADD: begin dec_p0.regwrite = 1'b1; dec_p0.alu_ctrl = ALU_ADD; end
                        F_SUB: begin dec_p0.regwrite = 1'b1; dec_p0.alu_ctrl = ALU_SUB; end
                        F_AND: begin dec_p0.regwrite = 1'b1; dec_p0.alu_ctrl = ALU_AND; end
                        F_OR:  begin dec_p0.regwrite = 1'b1; dec_p0.alu_ctrl = ALU_OR;  end
                        F_XOR: begin dec_p0.regwrite = 1'b1; dec_p0.alu_ctrl = ALU_XOR; end
                        F_SLT: begin dec_p0.regwrite = 1'b1; dec_p0.alu_ctrl = ALU_SLT; end
                        F_SLL: begin
                            dec_p0.regwrite = 1'b1; dec_p0.is_shift = 1'b1; dec_p0.alu_ctrl = ALU_SLL;
                        end
                        F_SRL: begin
                            dec_p0.regwrite = 1'b1; dec_p0.is_shift = 1'b1; dec_p0.alu_ctrl = ALU_SRL;
                        end
                        F_SRA: begin
                            dec_p0.regwrite = 1'b1; dec_p0.is_shift = 1'b1; dec_p0.alu_ctrl = ALU_SRA;
                        end
                        F_JR:  dec_p0.jr = 1'b1;
`ifdef ID_CTRL_MDU_EN
                        F_MULT:  dec_p0.mdu_op = MDU_MULT;
                        F_MULTU: dec_p0.mdu_op = MDU_MULTU;
                        F_DIV:   dec_p0.mdu_op = MDU_DIV;
                        F_DIVU:  dec_p0.mdu_op = MDU_DIVU;
                        F_MFHI:  begin dec_p0.regwrite = 1'b1; dec_p0.mdu_op = MDU_MFHI; end
                        F_MFLO:  begin dec_p0.regwrite = 1'b1; dec_p0.mdu_op = MDU_MFLO; end
`endif
                        default: begin dec_p0 = '0; dec_p0.illegal = 1'b1; end
                    endcase
                end
                OP_ADDI, OP_ORI, OP_XORI, OP_LUI: begin
                    dec_p0.regwrite = 1'b1;
                    dec_p0.alusrc   = 1'b1;
                    dec_p0.wdst     = rt;
                    case (opcode)
                        OP_ADDI: dec_p0.alu_ctrl = ALU_ADD;
                        OP_ORI:  dec_p0.alu_ctrl = ALU_OR;
                        OP_XORI: dec_p0.alu_ctrl = ALU_XOR;
                        default: dec_p0.alu_ctrl = ALU_LUI;
                    endcase
                end
                OP_LW: begin
                    dec_p0.regwrite = 1'b1; dec_p0.memread = 1'b1; dec_p0.memtoreg = 1'b1;
                    dec_p0.alusrc   = 1'b1; dec_p0.alu_ctrl = ALU_ADD; dec_p0.wdst = rt;
                end
                OP_SW: begin
                    dec_p0.memwrite = 1'b1; dec_p0.alusrc = 1'b1;
                    dec_p0.alu_ctrl = ALU_ADD; dec_p0.wdst = rt;
                end
                OP_BEQ, OP_BNE: begin
                    dec_p0.branch    = 1'b1;
                    dec_p0.branch_ne = (opcode == OP_BNE);
                    dec_p0.alu_ctrl  = ALU_SUB;
                    dec_p0.wdst      = rt;
                end
                OP_J:   dec_p0.jump = 1'b1;
                OP_JAL: begin
                    dec_p0.jump = 1'b1; dec_p0.wb_pc_plus4 = 1'b1;
                    dec_p0.regwrite = 1'b1; dec_p0.wdst = RA_W;
                end
                default: dec_p0.illegal = 1'b1;
            endcase
            // $0 is hard-wired, so a write to it is dropped at decode
            if (dec_p0.wdst == 5'd0) dec_p0.regwrite = 1'b0;
        end
    end

    assign uses_rt_p0  = (opcode == OP_RTYPE) || (opcode == OP_SW) ||
                         (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign load_use_p0 = vld_p1 && ex_q_p1.memread && (ex_q_p1.wdst != 5'd0) &&
                         ((ex_q_p1.wdst == rs) || (uses_rt_p0 && (ex_q_p1.wdst == rt)));
    assign hold_p0     = vld_p1 && !ex_ready;
    assign bubble_p0   = id_valid && (load_use_p0 || mdu_hz_p0);
    assign issue_p0    = !flush && !hold_p0 && id_valid && !bubble_p0;
    assign stall_id    = !rst && !flush && (hold_p0 || bubble_p0);

`ifdef ID_CTRL_MDU_EN
    logic [3:0] mdu_cnt;

    assign mdu_busy  = !rst && (mdu_cnt != 4'd0);
    assign mdu_hz_p0 = mdu_busy && (dec_p0.mdu_op != MDU_NONE);

    // Counter keeps running through flush and hold; only reset or a new mult/div reloads it
    always_ff @(posedge clk) begin
        if (rst) begin
            mdu_cnt <= 4'd0;
        end else if (issue_p0 && (dec_p0.mdu_op == MDU_MULT || dec_p0.mdu_op == MDU_MULTU)) begin
            mdu_cnt <= MULT_LAT_W;
        end else if (issue_p0 && (dec_p0.mdu_op == MDU_DIV || dec_p0.mdu_op == MDU_DIVU)) begin
            mdu_cnt <= DIV_LAT_W;
        end else if (mdu_cnt != 4'd0) begin
            mdu_cnt <= mdu_cnt - 4'd1;
        end
    end
`else
    logic unused_lat;

    assign unused_lat = ^{MULT_LAT_W, DIV_LAT_W};
    assign mdu_busy   = 1'b0;
    assign mdu_hz_p0  = 1'b0;
`endif

    // ---- ID -> EX register ----
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_p1  <= 1'b0;
            ex_q_p1 <= '0;
        end else if (!hold_p0) begin
            vld_p1  <= issue_p0;
            ex_q_p1 <= issue_p0 ? dec_p0 : '0;
        end
    end

    assign ex_valid       = vld_p1;
    assign ex_regwrite    = ex_q_p1.regwrite;
    assign ex_memwrite    = ex_q_p1.memwrite;
    assign ex_memread     = ex_q_p1.memread;
    assign ex_memtoreg    = ex_q_p1.memtoreg;
    assign ex_alusrc      = ex_q_p1.alusrc;
    assign ex_is_shift    = ex_q_p1.is_shift;
    assign ex_branch      = ex_q_p1.branch;
    assign ex_branch_ne   = ex_q_p1.branch_ne;
    assign ex_jump        = ex_q_p1.jump;
    assign ex_jr          = ex_q_p1.jr;
    assign ex_wb_pc_plus4 = ex_q_p1.wb_pc_plus4;
    assign ex_alu_ctrl    = ex_q_p1.alu_ctrl;
    assign ex_wdst        = ex_q_p1.wdst;
    assign ex_mdu_op      = ex_q_p1.mdu_op;
    assign ex_illegal     = ex_q_p1.illegal;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Testbench for id_ctrl_stage: hand-written decode vectors, directed hazard/hold/flush/reset sequences,
// and randomized traffic against a table-based reference model. Define ID_CTRL_MDU_EN to cover the MDU build.
module tb_id_ctrl_stage;

    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 12;
    localparam int RA_REG   = 31;

    logic        clk = 1'b0;
    logic        rst, id_valid, flush, ex_ready;
    logic [31:0] instr_id;
    logic        stall_id, ex_valid, ex_regwrite, ex_memwrite, ex_memread, ex_memtoreg;
    logic        ex_alusrc, ex_is_shift, ex_branch, ex_branch_ne, ex_jump, ex_jr, ex_wb_pc_plus4;
    logic [3:0]  ex_alu_ctrl;
    logic [4:0]  ex_wdst;
    logic [2:0]  ex_mdu_op;
    logic        ex_illegal, mdu_busy;

    id_ctrl_stage #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .RA_REG(RA_REG)) dut (
        .clk(clk), .rst(rst), .instr_id(instr_id), .id_valid(id_valid), .flush(flush),
        .ex_ready(ex_ready), .stall_id(stall_id), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_memwrite(ex_memwrite), .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg),
        .ex_alusrc(ex_alusrc), .ex_is_shift(ex_is_shift), .ex_branch(ex_branch),
        .ex_branch_ne(ex_branch_ne), .ex_jump(ex_jump), .ex_jr(ex_jr),
        .ex_wb_pc_plus4(ex_wb_pc_plus4), .ex_alu_ctrl(ex_alu_ctrl), .ex_wdst(ex_wdst),
        .ex_mdu_op(ex_mdu_op), .ex_illegal(ex_illegal), .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    // {valid, 11 controls, alu[3:0], wdst[4:0], mdu[2:0], illegal}
    logic [24:0] dut_bus;
    assign dut_bus = {ex_valid, ex_regwrite, ex_memwrite, ex_memread, ex_memtoreg, ex_alusrc,
                      ex_is_shift, ex_branch, ex_branch_ne, ex_jump, ex_jr, ex_wb_pc_plus4,
                      ex_alu_ctrl, ex_wdst, ex_mdu_op, ex_illegal};

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Instruction property table: dst 0=none 1=rd 2=rt 3=return-address register
    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [10:0] ctl;
        logic [3:0]  alu;
        logic [1:0]  dst;
        logic [2:0]  mdu;
    } ent_t;
    ent_t dec_tab[$];

    task automatic build_table();
        dec_tab.push_back('{6'h00, 6'h20, 11'b10000000000, 4'b0010, 2'd1, 3'd0});
        dec_tab.push_back('{6'h00, 6'h22, 11'b10000000000, 4'b0110, 2'd1, 3'd0});
        dec_tab.push_back('{6'h00, 6'h24, 11'b10000000000, 4'b0000, 2'd1, 3'd0});
        dec_tab.push_back('{6'h00, 6'h25, 11'b10000000000, 4'b0001, 2'd1, 3'd0});
        dec_tab.push_back('{6'h00, 6'h26, 11'b10000000000, 4'b0011, 2'd1, 3'd0});
        dec_tab.push_back('{6'h00, 6'h2A, 11'b10000000000, 4'b0111, 2'd1, 3'd0});
        dec_tab.push_back('{6'h00, 6'h00, 11'b10000100000, 4'b1000, 2'd1, 3'd0});
        dec_tab.push_back('{6'h00, 6'h02, 11'b10000100000, 4'b1010, 2'd1, 3'd0});
        dec_tab.push_back('{6'h00, 6'h03, 11'b10000100000, 4'b1011, 2'd1, 3'd0});
        dec_tab.push_back('{6'h00, 6'h08, 11'b00000000010, 4'b0000, 2'd1, 3'd0});
        dec_tab.push_back('{6'h08, 6'h00, 11'b10001000000, 4'b0010, 2'd2, 3'd0});
        dec_tab.push_back('{6'h0D, 6'h00, 11'b10001000000, 4'b0001, 2'd2, 3'd0});
        dec_tab.push_back('{6'h0E, 6'h00, 11'b10001000000, 4'b0011, 2'd2, 3'd0});
        dec_tab.push_back('{6'h0F, 6'h00, 11'b10001000000, 4'b1001, 2'd2, 3'd0});
        dec_tab.push_back('{6'h23, 6'h00, 11'b10111000000, 4'b0010, 2'd2, 3'd0});
        dec_tab.push_back('{6'h2B, 6'h00, 11'b01001000000, 4'b0010, 2'd2, 3'd0});
        dec_tab.push_back('{6'h04, 6'h00, 11'b00000010000, 4'b0110, 2'd2, 3'd0});
        dec_tab.push_back('{6'h05, 6'h00, 11'b00000011000, 4'b0110, 2'd2, 3'd0});
        dec_tab.push_back('{6'h02, 6'h00, 11'b00000000100, 4'b0000, 2'd0, 3'd0});
        dec_tab.push_back('{6'h03, 6'h00, 11'b10000000101, 4'b0000, 2'd3, 3'd0});
`ifdef ID_CTRL_MDU_EN
        dec_tab.push_back('{6'h00, 6'h18, 11'b00000000000, 4'b0000, 2'd1, 3'd1});
        dec_tab.push_back('{6'h00, 6'h19, 11'b00000000000, 4'b0000, 2'd1, 3'd2});
        dec_tab.push_back('{6'h00, 6'h1A, 11'b00000000000, 4'b0000, 2'd1, 3'd3});
        dec_tab.push_back('{6'h00, 6'h1B, 11'b00000000000, 4'b0000, 2'd1, 3'd4});
        dec_tab.push_back('{6'h00, 6'h10, 11'b10000000000, 4'b0000, 2'd1, 3'd5});
        dec_tab.push_back('{6'h00, 6'h12, 11'b10000000000, 4'b0000, 2'd1, 3'd6});
`endif
    endtask

    // Expected 24-bit bundle (without valid) for one instruction word
    function automatic logic [23:0] ref_decode(input logic [31:0] ins);
        logic [10:0] ctl;
        logic [4:0]  w;
        if (ins == 32'd0) return 24'd0;
        foreach (dec_tab[i]) begin
            if (dec_tab[i].op == ins[31:26] && (ins[31:26] != 6'h00 || dec_tab[i].fn == ins[5:0])) begin
                ctl = dec_tab[i].ctl;
                case (dec_tab[i].dst)
                    2'd1:    w = ins[15:11];
                    2'd2:    w = ins[20:16];
                    2'd3:    w = 5'(RA_REG);
                    default: w = 5'd0;
                endcase
                if (w == 5'd0) ctl[10] = 1'b0;
                return {ctl, dec_tab[i].alu, w, dec_tab[i].mdu, 1'b0};
            end
        end
        return 24'd1;
    endfunction

    logic [24:0] m_bus = '0;
    int          m_cnt = 0;
    logic        last_stall, last_busy;

    // One clock: drive, check combinational outputs, clock, advance the model, check EX bundle
    task automatic step(input logic r, input logic [31:0] ins, input logic iv, input logic fl, input logic rdy);
        logic [23:0] d;
        logic [4:0]  ew;
        logic        urt, lu, mhz, hold, st, bsy;
        @(negedge clk);
        rst = r; instr_id = ins; id_valid = iv; flush = fl; ex_ready = rdy;
        #1;
        d    = ref_decode(ins);
        bsy  = !r && (m_cnt > 0);
        ew   = m_bus[8:4];
        urt  = ins[31:26] == 6'h00 || ins[31:26] == 6'h2B || ins[31:26] == 6'h04 || ins[31:26] == 6'h05;
        lu   = m_bus[24] && m_bus[21] && ew != 5'd0 && (ew == ins[25:21] || (urt && ew == ins[20:16]));
        mhz  = bsy && d[3:1] != 3'd0;
        hold = m_bus[24] && !rdy;
        st   = !r && !fl && (hold || (iv && (lu || mhz)));
        last_stall = stall_id;
        last_busy  = mdu_busy;
        chk("stall_id", {31'd0, stall_id}, {31'd0, st});
        chk("mdu_busy", {31'd0, mdu_busy}, {31'd0, bsy});
        @(posedge clk);
        if (r) begin
            m_bus = '0;
            m_cnt = 0;
        end else begin
            if (m_cnt > 0) m_cnt--;
            if (fl) m_bus = '0;
            else if (!hold) begin
                if (iv && !(lu || mhz)) begin
                    m_bus = {1'b1, d};
                    if (d[3:1] == 3'd1 || d[3:1] == 3'd2) m_cnt = MULT_LAT;
                    else if (d[3:1] == 3'd3 || d[3:1] == 3'd4) m_cnt = DIV_LAT;
                end else m_bus = '0;
            end
        end
        #1;
        chk("ex_bundle", {7'd0, dut_bus}, {7'd0, m_bus});
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [10:0] ctl;
        logic [3:0]  alu;
        logic [4:0]  wdst;
        logic [2:0]  mdu;
        logic        ill;
    } vec_t;
    vec_t vt[$];

    localparam logic [5:0] RFN [14] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00,
                                        6'h02, 6'h03, 6'h08, 6'h18, 6'h1A, 6'h10, 6'h12};
    localparam logic [5:0] IOP [10] = '{6'h08, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04,
                                        6'h05, 6'h02, 6'h03};

    function automatic logic [31:0] rand_instr();
        int k;
        logic [4:0] a, b, c;
        k = $urandom_range(0, 29);
        a = 5'($urandom_range(0, 3));
        b = 5'($urandom_range(0, 3));
        c = 5'($urandom_range(0, 3));
        if (k < 14) return {6'h00, a, b, c, 5'($urandom_range(0, 31)), RFN[k]};
        if (k < 26) return {IOP[k % 10], a, b, 16'($urandom)};
        if (k < 28) return 32'($urandom);
        return 32'd0;
    endfunction

    localparam logic [31:0] I_LW8   = 32'h8C080000;  // lw  $8,0($0)
    localparam logic [31:0] I_ADD98 = 32'h01014820;  // add $9,$8,$1
    localparam logic [31:0] I_SUB3  = 32'h00221822;  // sub $3,$1,$2
    localparam logic [31:0] I_ADD3  = 32'h00221820;  // add $3,$1,$2

    initial begin
        logic [24:0] saved;
        int stalls;
        build_table();
        rst = 1'b1; instr_id = '0; id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;

        step(1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("reset_bus", {7'd0, dut_bus}, 32'd0);

        vt.push_back('{"add",  32'h00221820, 11'b10000000000, 4'b0010, 5'd3, 3'd0, 1'b0});
        vt.push_back('{"sub",  32'h00221822, 11'b10000000000, 4'b0110, 5'd3, 3'd0, 1'b0});
        vt.push_back('{"and",  32'h00221824, 11'b10000000000, 4'b0000, 5'd3, 3'd0, 1'b0});
        vt.push_back('{"or",   32'h00221825, 11'b10000000000, 4'b0001, 5'd3, 3'd0, 1'b0});
        vt.push_back('{"xor",  32'h00221826, 11'b10000000000, 4'b0011, 5'd3, 3'd0, 1'b0});
        vt.push_back('{"slt",  32'h0022182A, 11'b10000000000, 4'b0111, 5'd3, 3'd0, 1'b0});
        vt.push_back('{"sll",  32'h00022900, 11'b10000100000, 4'b1000, 5'd5, 3'd0, 1'b0});
        vt.push_back('{"srl",  32'h00022902, 11'b10000100000, 4'b1010, 5'd5, 3'd0, 1'b0});
        vt.push_back('{"sra",  32'h00022903, 11'b10000100000, 4'b1011, 5'd5, 3'd0, 1'b0});
        vt.push_back('{"jr",   32'h03E00008, 11'b00000000010, 4'b0000, 5'd0, 3'd0, 1'b0});
        vt.push_back('{"addi", 32'h20240007, 11'b10001000000, 4'b0010, 5'd4, 3'd0, 1'b0});
        vt.push_back('{"ori",  32'h34240007, 11'b10001000000, 4'b0001, 5'd4, 3'd0, 1'b0});
        vt.push_back('{"xori", 32'h38240007, 11'b10001000000, 4'b0011, 5'd4, 3'd0, 1'b0});
        vt.push_back('{"lui",  32'h3C041234, 11'b10001000000, 4'b1001, 5'd4, 3'd0, 1'b0});
        vt.push_back('{"sw",   32'hAC280004, 11'b01001000000, 4'b0010, 5'd8, 3'd0, 1'b0});
        vt.push_back('{"beq",  32'h10220010, 11'b00000010000, 4'b0110, 5'd2, 3'd0, 1'b0});
        vt.push_back('{"bne",  32'h14220010, 11'b00000011000, 4'b0110, 5'd2, 3'd0, 1'b0});
        vt.push_back('{"lw",   32'h8C080000, 11'b10111000000, 4'b0010, 5'd8, 3'd0, 1'b0});
        vt.push_back('{"j",    32'h08000010, 11'b00000000100, 4'b0000, 5'd0, 3'd0, 1'b0});
        vt.push_back('{"jal",  32'h0C000010, 11'b10000000101, 4'b0000, 5'd31, 3'd0, 1'b0});
        vt.push_back('{"addi_r0", 32'h20000005, 11'b00001000000, 4'b0010, 5'd0, 3'd0, 1'b0});
        vt.push_back('{"nop",  32'h00000000, 11'b00000000000, 4'b0000, 5'd0, 3'd0, 1'b0});
        vt.push_back('{"bad_op", 32'hFC000000, 11'b00000000000, 4'b0000, 5'd0, 3'd0, 1'b1});
        vt.push_back('{"bad_fn", 32'h00221801, 11'b00000000000, 4'b0000, 5'd0, 3'd0, 1'b1});
`ifdef ID_CTRL_MDU_EN
        vt.push_back('{"mflo", 32'h00005012, 11'b10000000000, 4'b0000, 5'd10, 3'd6, 1'b0});
        vt.push_back('{"mult", 32'h00220018, 11'b00000000000, 4'b0000, 5'd0, 3'd1, 1'b0});
`else
        vt.push_back('{"mult_ill", 32'h00220018, 11'b00000000000, 4'b0000, 5'd0, 3'd0, 1'b1});
        vt.push_back('{"mflo_ill", 32'h00005012, 11'b00000000000, 4'b0000, 5'd0, 3'd0, 1'b1});
`endif
        foreach (vt[i]) begin
            step(1'b0, vt[i].instr, 1'b1, 1'b0, 1'b1);
            chk(vt[i].name, {7'd0, dut_bus},
                {7'd0, 1'b1, vt[i].ctl, vt[i].alu, vt[i].wdst, vt[i].mdu, vt[i].ill});
        end
        for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);

        // Load-use: one stall cycle, one bubble, then the dependent add issues
        step(1'b0, I_LW8, 1'b1, 1'b0, 1'b1);
        step(1'b0, I_ADD98, 1'b1, 1'b0, 1'b1);
        chk("lu_stall", {31'd0, last_stall}, 32'd1);
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        step(1'b0, I_ADD98, 1'b1, 1'b0, 1'b1);
        chk("lu_nostall", {31'd0, last_stall}, 32'd0);
        chk("lu_add", {20'd0, ex_valid, ex_wdst, ex_alu_ctrl, 2'd0}, {20'd0, 1'b1, 5'd9, 4'b0010, 2'd0});

        // Hold: sub stays in EX for three cycles, then add issues on release
        step(1'b0, I_SUB3, 1'b1, 1'b0, 1'b1);
        saved = dut_bus;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, I_ADD3, 1'b1, 1'b0, 1'b0);
            chk("hold_stall", {31'd0, last_stall}, 32'd1);
            chk("hold_bus", {7'd0, dut_bus}, {7'd0, saved});
        end
        step(1'b0, I_ADD3, 1'b1, 1'b0, 1'b1);
        chk("release_stall", {31'd0, last_stall}, 32'd0);
        chk("release_alu", {28'd0, ex_alu_ctrl}, 32'd2);

        // Flush in the same cycle as a load-use hazard
        step(1'b0, I_LW8, 1'b1, 1'b0, 1'b1);
        step(1'b0, I_ADD98, 1'b1, 1'b1, 1'b1);
        chk("flush_stall", {31'd0, last_stall}, 32'd0);
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);

        // Reset during hold: abandoned, and the next cycle issues without stall
        step(1'b0, I_SUB3, 1'b1, 1'b0, 1'b1);
        step(1'b0, I_ADD3, 1'b1, 1'b0, 1'b0);
        step(1'b1, I_ADD3, 1'b1, 1'b0, 1'b0);
        chk("rst_hold_stall", {31'd0, last_stall}, 32'd0);
        chk("rst_hold_bus", {7'd0, dut_bus}, 32'd0);
        step(1'b0, I_ADD3, 1'b1, 1'b0, 1'b0);
        chk("post_rst_stall", {31'd0, last_stall}, 32'd0);
        chk("post_rst_valid", {31'd0, ex_valid}, 32'd1);

`ifdef ID_CTRL_MDU_EN
        // mult then mflo: mflo waits MULT_LAT cycles
        step(1'b0, 32'h00220018, 1'b1, 1'b0, 1'b1);
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 32'h00005012, 1'b1, 1'b0, 1'b1);
            if (!last_stall) break;
            stalls++;
        end
        chk("mflo_stalls", 32'(stalls), 32'(MULT_LAT));
        chk("mflo_issue", {22'd0, ex_valid, ex_mdu_op, ex_wdst, 1'b0}, {22'd0, 1'b1, 3'd6, 5'd10, 1'b0});

        // div busy, reset five cycles in
        step(1'b0, 32'h0022001A, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        chk("div_busy", {31'd0, mdu_busy}, 32'd1);
        step(1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
        chk("div_rst_busy_in", {31'd0, last_busy}, 32'd0);
        chk("div_rst_bus", {7'd0, dut_bus}, 32'd0);
        #1;
        chk("div_rst_busy", {31'd0, mdu_busy}, 32'd0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), rand_instr(), ($urandom_range(0, 5) != 0),
                 ($urandom_range(0, 11) == 0), ($urandom_range(0, 4) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
